rs232_hex_word_sender: RTL and testbench
========================================

# rs232_hex_word_sender

Upstream feeder for the RS232 output serializer. Accepts binary words over a valid/ready handshake and converts each one to uppercase ASCII hex, most-significant nibble first, followed by a line terminator. It writes one character per cycle into the serializer's transmit FIFO, throttled by that FIFO's registered `fifo_write_space` report. It gives on-chip logic a printf-free way to dump register values to a terminal.

## Interface
- `WORD_WIDTH`, 32: input word width; multiple of 4, range 4..64; digits per word = `WORD_WIDTH/4`.
- `DATA_WIDTH`, 8: character width; must match the serializer's data width.
- `SPACE_THRESHOLD`, 3: minimum `fifo_write_space` required to issue a character.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `word_in`  in  `WORD_WIDTH`  word to print.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  block can accept a word; transfer happens on an edge with valid & ready.
- `fifo_write_space`  in  8  free FIFO entries (0..128) from the serializer; registered there.
- `transmit_data`  out  `DATA_WIDTH` [`DATA_WIDTH`:1]  ASCII character to the serializer.
- `transmit_data_en`  out  1  one-cycle write strobe to the serializer.
- `busy`  out  1  word accepted and not yet fully issued.

## Operation
- FSM states: IDLE, DIGIT, TERM1, TERM2.
  - IDLE: `word_ready`=1. On accept, load the word into a shift register, clear the digit counter, and go to DIGIT.
  - DIGIT: on each issue, output the top nibble of the shift register as ASCII, then shift left 4. After digit `WORD_WIDTH/4-1`, go to TERM1.
  - TERM1: issue CR (0x0D) and go to TERM2. With the CRLF macro absent, issue space (0x20) and go to IDLE instead.
  - TERM2: issue LF (0x0A) and go to IDLE.
- Nibble mapping: 0..9 map to 0x30..0x39; A..F map to 0x41..0x46.
- Issue condition: state is not IDLE and `fifo_write_space >= SPACE_THRESHOLD`. Otherwise stall: hold state, counter and shift register, and drive `transmit_data_en`=0.
  - `fifo_write_space` lags writes by 2 cycles, and the threshold of 3 covers the 2 in-flight writes.
  - Reads in the lag window only make the count pessimistic, so overflow is impossible.
- `transmit_data` and `transmit_data_en` are registered; `transmit_data` holds its last value when `en`=0.
- `word_ready` and `busy` are registered, mutually exclusive, and never both 0 after the first post-reset edge.
- Reset: asynchronous clear to IDLE.
  - `word_ready`=0, `busy`=0, `transmit_data_en`=0, `transmit_data`=0, shift register and counter 0.
  - `word_ready` rises on the first edge with `reset_n` high.
  - Reset mid-word abandons the partial line; no further strobes are issued for it.
- `word_valid` while not ready is ignored; `word_in` is sampled only on the accept edge.

## Timing
- Accept at edge t: `word_ready` and `busy` change at edge t.
- First character strobe is visible after edge t+1 if space ≥ 3.
- Unstalled, with CRLF: strobes on edges t+1..t+10. `word_ready` returns at edge t+10, so the next accept is at edge t+11 (11 cycles/word at 32 bits).
- Unstalled, without CRLF: strobes on edges t+1..t+9; next accept at edge t+10.
- Each stall cycle adds exactly one cycle. Characters are never dropped or duplicated across stalls.
- `transmit_data_en` is never high for more than `WORD_WIDTH/4+2` cycles per word.

## Configuration
- `RS232_HEX_CRLF_EN` defined: the terminator is CR then LF (TERM2 reachable).
- Undefined: the terminator is a single space 0x20, TERM2 is unreachable, and words print on one line.

## Test plan
- CRLF on, space=128, word 0x1234ABCD → 10 consecutive strobes: 31 32 33 34 41 42 43 44 0D 0A; `word_ready` high again at edge t+10.
- CRLF off, word 0x0000000F → 9 strobes: seven 0x30, then 0x46, then 0x20; next accept is possible at edge t+10.
- Space forced to 2 after the 3rd strobe of 0xDEADBEEF for 5 cycles, then 3 → no strobes during the hold; output resumes with 0x44 (4th digit); the full string is intact.
- `word_valid` held high with words 0x00000001 then 0xFFFFFFFF → second word accepted exactly at edge t+11; `word_in` changes while busy are ignored.
- `reset_n` pulsed low after the 4th strobe → `transmit_data_en`=0 and `transmit_data`=0 immediately; `word_ready` goes 1 one edge after release; next word 0x00000000 prints from digit 0.
- `WORD_WIDTH`=8, CRLF on, word 0x9F → 39 46 0D 0A.

Source files
------------

// File: rtl/rs232_hex_word_sender.sv
// Prints accepted binary words as uppercase ASCII hex (MS nibble first) plus a terminator into the
// RS232 serializer FIFO. Define RS232_HEX_CRLF_EN for a CR LF terminator; otherwise a single space.
module rs232_hex_word_sender #(
    parameter int WORD_WIDTH      = 32,
    parameter int DATA_WIDTH      = 8,
    parameter int SPACE_THRESHOLD = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [7:0]            fifo_write_space,
    output logic [DATA_WIDTH:1]   transmit_data,
    output logic                  transmit_data_en,
    output logic                  busy
);
    localparam int DIGITS = WORD_WIDTH / 4;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);
    localparam logic [7:0] SPACE_MIN = 8'(SPACE_THRESHOLD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIGIT = 2'd1;
    localparam logic [1:0] S_TERM1 = 2'd2;
    localparam logic [1:0] S_TERM2 = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      digit_cnt_q, digit_cnt_d;
    logic [DATA_WIDTH:1]   transmit_data_q, transmit_data_d;
    logic                  transmit_data_en_q, transmit_data_en_d;
    logic                  word_ready_q, word_ready_d;
    logic                  busy_q, busy_d;

    logic [3:0] nibble;
    logic [7:0] nibble_ascii;
    logic       issue;

    assign nibble       = shift_q[WORD_WIDTH-1 -: 4];
    assign nibble_ascii = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
    // The threshold absorbs the writes still in flight while the registered space report lags.
    assign issue        = (state_q != S_IDLE) && (fifo_write_space >= SPACE_MIN);

    always_comb begin
        state_d            = state_q;
        shift_d            = shift_q;
        digit_cnt_d        = digit_cnt_q;
        transmit_data_d    = transmit_data_q;
        transmit_data_en_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (word_ready_q && word_valid) begin
                    state_d     = S_DIGIT;
                    shift_d     = word_in;
                    digit_cnt_d = '0;
                end
            end
            S_DIGIT: begin
                if (issue) begin
                    transmit_data_d    = DATA_WIDTH'(nibble_ascii);
                    transmit_data_en_d = 1'b1;
                    shift_d            = shift_q << 4;
                    if (digit_cnt_q == LAST_DIGIT) begin
                        state_d = S_TERM1;
                    end else begin
                        digit_cnt_d = digit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_TERM1: begin
                if (issue) begin
                    transmit_data_en_d = 1'b1;
`ifdef RS232_HEX_CRLF_EN
                    transmit_data_d    = DATA_WIDTH'(8'h0D);
                    state_d            = S_TERM2;
`else
                    transmit_data_d    = DATA_WIDTH'(8'h20);
                    state_d            = S_IDLE;
`endif
                end
            end
            S_TERM2: begin
                if (issue) begin
                    transmit_data_en_d = 1'b1;
                    transmit_data_d    = DATA_WIDTH'(8'h0A);
                    state_d            = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready returns on the same edge as the final terminator strobe.
        word_ready_d = (state_d == S_IDLE);
        busy_d       = ~word_ready_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= S_IDLE;
            shift_q            <= '0;
            digit_cnt_q        <= '0;
            transmit_data_q    <= '0;
            transmit_data_en_q <= 1'b0;
            word_ready_q       <= 1'b0;
            busy_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            shift_q            <= shift_d;
            digit_cnt_q        <= digit_cnt_d;
            transmit_data_q    <= transmit_data_d;
            transmit_data_en_q <= transmit_data_en_d;
            word_ready_q       <= word_ready_d;
            busy_q             <= busy_d;
        end
    end

    assign word_ready       = word_ready_q;
    assign busy             = busy_q;
    assign transmit_data    = transmit_data_q;
    assign transmit_data_en = transmit_data_en_q;

endmodule

// File: tb/tb_rs232_hex_word_sender.sv
// Self-checking bench for rs232_hex_word_sender: 32-bit and 8-bit instances, character scoreboard
// plus hand-written timing, stall, held-valid and mid-word reset sequences.
module tb_rs232_hex_word_sender;

`ifdef RS232_HEX_CRLF_EN
    localparam int TERM_N = 2;
`else
    localparam int TERM_N = 1;
`endif
    localparam int N_CHARS32 = 8 + TERM_N;
    localparam int N_CHARS8  = 2 + TERM_N;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  space;
    logic [8:1]  tx_data;
    logic        tx_en;
    logic        busy;

    logic [7:0]  word8_in;
    logic        valid8;
    logic        ready8;
    logic [7:0]  space8;
    logic [8:1]  tx8_data;
    logic        tx8_en;
    logic        busy8;

    int errors = 0;
    int checks = 0;
    bit rand_space = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] exp8_q[$];

    typedef struct {
        logic [31:0] word;
        logic [63:0] text;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    rs232_hex_word_sender #(.WORD_WIDTH(32), .DATA_WIDTH(8), .SPACE_THRESHOLD(3)) dut32 (
        .clk(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .fifo_write_space(space), .transmit_data(tx_data),
        .transmit_data_en(tx_en), .busy(busy)
    );

    rs232_hex_word_sender #(.WORD_WIDTH(8), .DATA_WIDTH(8), .SPACE_THRESHOLD(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .word_in(word8_in), .word_valid(valid8),
        .word_ready(ready8), .fifo_write_space(space8), .transmit_data(tx8_data),
        .transmit_data_en(tx8_en), .busy(busy8)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushTerm(input bit to8);
        logic [7:0] t[$];
`ifdef RS232_HEX_CRLF_EN
        t = '{8'h0D, 8'h0A};
`else
        t = '{8'h20};
`endif
        foreach (t[i]) begin
            if (to8) exp8_q.push_back(t[i]);
            else     exp_q.push_back(t[i]);
        end
    endtask

    task automatic pushText32(input logic [63:0] text);
        for (int i = 0; i < 8; i++) exp_q.push_back(text[63-8*i -: 8]);
        pushTerm(1'b0);
    endtask

    task automatic pushText8(input logic [15:0] text);
        for (int i = 0; i < 2; i++) exp8_q.push_back(text[15-8*i -: 8]);
        pushTerm(1'b1);
    endtask

    // Scoreboards: every strobe must match the oldest expected character.
    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("strobe_expected32", tx_en, 1'b0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("char32", tx_data, e);
            end
        end
        if (tx8_en) begin
            if (exp8_q.size() == 0) begin
                checkOutput("strobe_expected8", tx8_en, 1'b0);
            end else begin
                e = exp8_q.pop_front();
                checkOutput("char8", tx8_data, e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_space) begin
            #2;
            space = 8'($urandom_range(0, 6));
        end
    end

    // Called and returning at posedge+1; accept happens on the edge it waits for.
    task automatic applyStimulus(input logic [31:0] w, input logic [63:0] text, input bit keep_valid);
        int n = 0;
        while (word_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ready_before_send", word_ready, 1'b1);
        pushText32(text);
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) word_valid = 1'b0;
        checkOutput("accepted_busy", busy, 1'b1);
        checkOutput("accepted_not_ready", word_ready, 1'b0);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (!(exp_q.size() == 0 && exp8_q.size() == 0 && word_ready && ready8) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_done", (exp_q.size() == 0 && exp8_q.size() == 0 && word_ready && ready8), 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int n;
        vecs[0] = '{32'h89ABCDEF, "89ABCDEF"};
        vecs[1] = '{32'h01234567, "01234567"};
        vecs[2] = '{32'hFEDCBA98, "FEDCBA98"};
        vecs[3] = '{32'hA5A5C3C3, "A5A5C3C3"};
        vecs[4] = '{32'h90000009, "90000009"};
        vecs[5] = '{32'h7F7F0E0E, "7F7F0E0E"};

        reset_n = 1'b0; word_valid = 1'b0; word_in = '0; space = 8'd128;
        valid8 = 1'b0; word8_in = '0; space8 = 8'd128;

        #1;
        checkOutput("reset_ready", word_ready, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_en", tx_en, 1'b0);
        checkOutput("reset_data", tx_data, 8'h00);
        @(posedge clk); #1;
        checkOutput("reset_hold_ready", word_ready, 1'b0);
        reset_n = 1'b1;
        checkOutput("ready_before_first_edge", word_ready, 1'b0);
        @(posedge clk); #1;
        checkOutput("ready_after_first_edge", word_ready, 1'b1);
        checkOutput("busy_after_first_edge", busy, 1'b0);
        checkOutput("ready8_after_first_edge", ready8, 1'b1);

        // Unstalled run: strobes on every edge t+1..t+N, ready back exactly at t+N.
        applyStimulus(32'h1234ABCD, "1234ABCD", 1'b0);
        for (int k = 1; k <= N_CHARS32; k++) begin
            @(posedge clk); #1;
            checkOutput("strobe_run", tx_en, 1'b1);
            checkOutput("ready_timing", word_ready, (k == N_CHARS32));
        end
        @(posedge clk); #1;
        checkOutput("no_extra_strobe", tx_en, 1'b0);

        applyStimulus(32'h0000000F, "0000000F", 1'b0);
        waitDrain();

        // Table of words under randomly throttled FIFO space.
        rand_space = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].word, vecs[i].text, 1'b0);
        waitDrain();
        rand_space = 1'b0;
        @(posedge clk); #1;
        space = 8'd128;

        // Stall after the third digit; must resume with the fourth.
        applyStimulus(32'hDEADBEEF, "DEADBEEF", 1'b0);
        cnt = 0; n = 0;
        while (cnt < 3 && n < 50) begin
            @(posedge clk); #1;
            if (tx_en) cnt++;
            n++;
        end
        checkOutput("stall_reach3", cnt, 3);
        space = 8'd2;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("stall_no_strobe", tx_en, 1'b0);
        end
        space = 8'd3;
        @(posedge clk); #1;
        checkOutput("resume_strobe", tx_en, 1'b1);
        checkOutput("resume_char", tx_data, 8'h44);
        space = 8'd128;
        waitDrain();

        // Valid held high: second word taken exactly one edge after ready returns.
        applyStimulus(32'h00000001, "00000001", 1'b1);
        word_in = 32'hFFFFFFFF;
        pushText32("FFFFFFFF");
        for (int k = 1; k <= N_CHARS32; k++) begin
            @(posedge clk); #1;
            if (k == 3) word_in = 32'h55555555;
            if (k == 5) word_in = 32'hFFFFFFFF;
            checkOutput("held_ready", word_ready, (k == N_CHARS32));
            checkOutput("held_busy", busy, (k != N_CHARS32));
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        checkOutput("held_second_accept", busy, 1'b1);
        checkOutput("held_second_not_ready", word_ready, 1'b0);
        checkOutput("held_second_no_strobe_yet", tx_en, 1'b0);
        waitDrain();

        // Reset in the middle of a word abandons it.
        applyStimulus(32'h13579BDF, "13579BDF", 1'b0);
        cnt = 0; n = 0;
        while (cnt < 4 && n < 50) begin
            @(posedge clk); #1;
            if (tx_en) cnt++;
            n++;
        end
        checkOutput("reset_reach4", cnt, 4);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_en", tx_en, 1'b0);
        checkOutput("midreset_data", tx_data, 8'h00);
        checkOutput("midreset_ready", word_ready, 1'b0);
        checkOutput("midreset_busy", busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("midreset_hold_en", tx_en, 1'b0);
        reset_n = 1'b1;
        checkOutput("release_ready_low", word_ready, 1'b0);
        @(posedge clk); #1;
        checkOutput("release_ready_high", word_ready, 1'b1);
        checkOutput("release_no_strobe", tx_en, 1'b0);
        applyStimulus(32'h00000000, "00000000", 1'b0);
        waitDrain();

        // 8-bit instance.
        pushText8("9F");
        word8_in = 8'h9F;
        valid8   = 1'b1;
        @(posedge clk); #1;
        valid8 = 1'b0;
        checkOutput("w8_accept_busy", busy8, 1'b1);
        for (int k = 1; k <= N_CHARS8; k++) begin
            @(posedge clk); #1;
            checkOutput("w8_strobe_run", tx8_en, 1'b1);
            checkOutput("w8_ready_timing", ready8, (k == N_CHARS8));
        end
        pushText8("0A");
        word8_in = 8'h0A;
        valid8   = 1'b1;
        @(posedge clk); #1;
        valid8 = 1'b0;
        checkOutput("w8_second_accept", busy8, 1'b1);
        waitDrain();

        checkOutput("queues_empty", exp_q.size() + exp8_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
